// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Holds the alu32 opcode constants, the muldiv request op encodings, the
// sequencer state type and a small two's-complement negate helper.
package alu_muldiv_seq_pkg;

  // alu32 opcodes
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSll = 4'b1000;
  localparam logic [3:0] AluSrl = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;

  // Request op encodings; bit 0 selects divide, bit 1 selects signed.
  typedef enum logic [1:0] {
    OpMulu = 2'b00,
    OpDivu = 2'b01,
    OpMuls = 2'b10,
    OpDivs = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } state_e;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_alu32.sv
// alu32: 32-bit combinational ALU shared by the muldiv sequencer.
// Ports:
//   a_i, b_i  operands
//   op_i      opcode (AluAnd .. AluSra from alu_muldiv_seq_pkg)
//   y_o       result
//   cout_o    carry out of ADD; for SUB it is the no-borrow flag (a >= b unsigned)
module alu32
  import alu_muldiv_seq_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] y_o,
  output logic        cout_o
);

  logic        sub;
  logic [31:0] b_inv;
  logic [32:0] sum;

  // SUB and SLT share the adder as a + ~b + 1.
  assign sub   = (op_i == AluSub) || (op_i == AluSlt);
  assign b_inv = sub ? ~b_i : b_i;
  assign sum   = {1'b0, a_i} + {1'b0, b_inv} + {32'd0, sub};

  always_comb begin
    y_o    = '0;
    cout_o = 1'b0;
    case (op_i)
      AluAnd: y_o = a_i & b_i;
      AluOr:  y_o = a_i | b_i;
      AluAdd, AluSub: begin
        y_o    = sum[31:0];
        cout_o = sum[32];
      end
      AluSlt: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      AluSll: y_o = a_i << b_i[4:0];
      AluSrl: y_o = a_i >> b_i[4:0];
      AluSra: y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 32-iteration shift-add multiplier and restoring divider
// time-sharing one alu32, with valid/ready request and response handshakes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in idle)
//   req_op, req_a, req_b  00 MULU, 01 DIVU, 10 MULS, 11 DIVS; operands
//   resp_valid/resp_ready response handshake
//   resp_hi, resp_lo      product[63:32]/remainder, product[31:0]/quotient
//   busy                  not idle
//   div_zero              returned divide had a zero divisor
// Parameters: DIV0_FAST (divide by zero responds the cycle after accept),
//   ITER_W (iteration counter width, must hold 31).
// Macro MULDIV_SIGNED_EN enables signed MULS/DIVS; otherwise op[1] is ignored.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter bit          DIV0_FAST = 1'b1,
  parameter int unsigned ITER_W    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        busy,
  output logic        div_zero
);

  state_e            state_q;
  logic [ITER_W-1:0] cnt_q;
  logic [31:0]       b_q;       // multiplicand or divisor
  logic [31:0]       hi_q;      // product high / partial remainder
  logic [31:0]       lo_q;      // multiplier shift / quotient shift
  logic [31:0]       res_hi_q;
  logic [31:0]       res_lo_q;
  logic              div_zero_q;

  logic        is_div, b_zero, last, nb;
  logic [31:0] a_in, b_in;
  logic [31:0] alu_a, alu_b, alu_y, sh;
  logic [3:0]  alu_op;
  logic        alu_cout;
  logic [31:0] hi_n, lo_n, fin_hi, fin_lo;

`ifdef MULDIV_SIGNED_EN
  logic neg_res_q, neg_rem_q;
  logic sa, sb;
`else
  logic unused_op1;
  assign unused_op1 = req_op[1];
`endif

  assign is_div = req_op[0];
  assign b_zero = (req_b == 32'd0);
  assign last   = (cnt_q == ITER_W'(31));

  // Operand conditioning at accept.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    // The dividend is left alone for a zero divisor so the result comes out unsigned-style.
    sa   = req_op[1] & req_a[31] & ~b_zero;
    sb   = req_op[1] & req_b[31];
    a_in = sa ? neg32(req_a) : req_a;
    b_in = sb ? neg32(req_b) : req_b;
`else
    a_in = req_a;
    b_in = req_b;
`endif
  end

  // One iteration step through the shared ALU.
  always_comb begin
    sh     = {hi_q[30:0], lo_q[31]};
    alu_op = (state_q == StDiv) ? AluSub : AluAdd;
    alu_a  = (state_q == StDiv) ? sh : hi_q;
    alu_b  = ((state_q == StDiv) || lo_q[0]) ? b_q : 32'd0;
    // rem[31] set means the shifted value has a 33rd bit, so it always covers the divisor.
    nb     = alu_cout | hi_q[31];
    if (state_q == StDiv) begin
      hi_n = nb ? alu_y : sh;
      lo_n = {lo_q[30:0], nb};
    end else begin
      hi_n = {alu_cout, alu_y[31:1]};
      lo_n = {alu_y[0], lo_q[31:1]};
    end
    fin_hi = hi_n;
    fin_lo = lo_n;
`ifdef MULDIV_SIGNED_EN
    if (state_q == StDiv) begin
      if (neg_res_q) fin_lo = neg32(lo_n);
      if (neg_rem_q) fin_hi = neg32(hi_n);
    end else if (neg_res_q) begin
      {fin_hi, fin_lo} = ~{hi_n, lo_n} + 64'd1;
    end
`endif
  end

  alu32 u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .op_i   (alu_op),
    .y_o    (alu_y),
    .cout_o (alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cnt_q      <= '0;
            b_q        <= is_div ? b_in : a_in;
            div_zero_q <= is_div & b_zero;
`ifdef MULDIV_SIGNED_EN
            neg_res_q  <= sa ^ sb;
            neg_rem_q  <= sa;
`endif
            if (!is_div) begin
              hi_q    <= '0;
              lo_q    <= b_in;
              state_q <= StMul;
            end else if (b_zero && DIV0_FAST) begin
              res_hi_q <= req_a;
              res_lo_q <= '1;
              state_q  <= StDone;
            end else begin
              hi_q    <= '0;
              lo_q    <= a_in;
              state_q <= StDiv;
            end
          end
        end
        StMul, StDiv: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + ITER_W'(1);
          if (last) begin
            res_hi_q <= fin_hi;
            res_lo_q <= fin_lo;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StDone);
  assign resp_hi    = res_hi_q;
  assign resp_lo    = res_lo_q;
  assign div_zero   = div_zero_q;

endmodule
